// File: rtl/sobel_window_ctrl_pkg.sv
// rtl/sobel_window_ctrl_pkg.sv - shared types and constants for the Sobel window scheduler
// Pixel widths, 3x3 window typedefs, scheduler states and the column shift helper.
package sobel_window_ctrl_pkg;

  localparam int PIXEL_WIDTH_IN  = 8;
  localparam int PIXEL_WIDTH_OUT = 11;

  typedef struct packed {
    logic [PIXEL_WIDTH_IN-1:0] pix2;
    logic [PIXEL_WIDTH_IN-1:0] pix1;
    logic [PIXEL_WIDTH_IN-1:0] pix0;
  } sobel_vector;

  typedef struct packed {
    sobel_vector vector2;
    sobel_vector vector1;
    sobel_vector vector0;
  } sobel_matrix;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    FLUSH     = 2'd2,
    WAIT_DONE = 2'd3
  } sobel_state_e;

  // Oldest column falls out of pix0, the new column lands in pix2 of every row.
  function automatic sobel_matrix shift_in_column(input sobel_matrix m,
                                                  input logic [3*PIXEL_WIDTH_IN-1:0] col);
    sobel_matrix r;
    r.vector0.pix0 = m.vector0.pix1;
    r.vector0.pix1 = m.vector0.pix2;
    r.vector0.pix2 = col[0 +: PIXEL_WIDTH_IN];
    r.vector1.pix0 = m.vector1.pix1;
    r.vector1.pix1 = m.vector1.pix2;
    r.vector1.pix2 = col[PIXEL_WIDTH_IN +: PIXEL_WIDTH_IN];
    r.vector2.pix0 = m.vector2.pix1;
    r.vector2.pix1 = m.vector2.pix2;
    r.vector2.pix2 = col[2*PIXEL_WIDTH_IN +: PIXEL_WIDTH_IN];
    return r;
  endfunction

endpackage

// File: rtl/sobel_window_shift.sv
// rtl/sobel_window_shift.sv - 3x3 sliding window register with load-zero and shift-enable
// Also presents the would-be shifted window so the caller can capture it as the line clears.
module sobel_window_shift
  import sobel_window_ctrl_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_nreset,
  input  logic                        i_clear,
  input  logic                        i_shift,
  input  logic [3*PIXEL_WIDTH_IN-1:0] i_col,
  output sobel_matrix                 o_win_shifted
);

  sobel_matrix r_win;
  sobel_matrix w_win_shifted;

  assign w_win_shifted = shift_in_column(r_win, i_col);
  assign o_win_shifted = w_win_shifted;

  // Clear wins over shift: the end-of-line column is captured downstream, not kept here.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_win <= '0;
    end else if (i_clear) begin
      r_win <= '0;
    end else if (i_shift) begin
      r_win <= w_win_shifted;
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// rtl/sobel_window_ctrl.sv - streaming 3x3 window scheduler feeding sobel_core
// Optional SOBEL_BORDER_ZERO_EN pads each line with zero columns (width windows per line).
module sobel_window_ctrl
  import sobel_window_ctrl_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic                        clk_i,
  input  logic                        nreset_i,
  input  logic                        start_i,
  input  logic [CNT_W-1:0]            line_width_i,
  input  logic [CNT_W-1:0]            num_lines_i,
  input  logic                        col_valid_i,
  output logic                        col_ready_o,
  input  logic [3*PIXEL_WIDTH_IN-1:0] col_i,
  output logic                        win_valid_o,
  input  logic                        win_ready_i,
  output sobel_matrix                 win_o,
  output logic                        eol_o,
  output logic                        eof_o,
  output logic                        busy_o,
  output logic                        done_o
);

  sobel_state_e r_state;
  sobel_state_e w_state_next;

  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_lines;
  logic [CNT_W-1:0] r_col_cnt;
  logic [CNT_W-1:0] r_line_cnt;

  logic        r_win_valid;
  sobel_matrix r_win;
  logic        r_eol;
  logic        r_eof;
  logic        r_done;

  logic                        w_slot_free;
  logic                        w_start_ok;
  logic                        w_accept;
  logic                        w_last_col;
  logic                        w_last_line;
  logic                        w_shift;
  logic                        w_clear;
  logic                        w_emit;
  logic                        w_eol;
  logic                        w_eof;
  logic                        w_line_end;
  logic                        w_done;
  logic [3*PIXEL_WIDTH_IN-1:0] w_shift_col;
  sobel_matrix                 w_win_shifted;

  assign w_slot_free = !r_win_valid || win_ready_i;
  assign col_ready_o = (r_state == RUN) && w_slot_free;
  assign w_accept    = col_valid_i && col_ready_o;
  assign w_start_ok  = (r_state == IDLE) && start_i &&
                       (line_width_i >= CNT_W'(3)) && (num_lines_i != '0);
  assign w_last_col  = (r_col_cnt == r_width - CNT_W'(1));
  assign w_last_line = (r_line_cnt == r_lines - CNT_W'(1));

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift      = 1'b0;
    w_clear      = 1'b0;
    w_emit       = 1'b0;
    w_eol        = 1'b0;
    w_eof        = 1'b0;
    w_line_end   = 1'b0;
    w_done       = 1'b0;
    w_shift_col  = col_i;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_clear      = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_accept) begin
          w_shift = 1'b1;
`ifdef SOBEL_BORDER_ZERO_EN
          // The cleared window already acts as the leading zero column.
          w_emit = (r_col_cnt >= CNT_W'(1));
          if (w_last_col) begin
            w_state_next = FLUSH;
          end
`else
          w_emit = (r_col_cnt >= CNT_W'(2));
          if (w_last_col) begin
            w_clear    = 1'b1;
            w_line_end = 1'b1;
            w_eol      = 1'b1;
            w_eof      = w_last_line;
            if (w_last_line) begin
              w_state_next = WAIT_DONE;
            end
          end
`endif
        end
      end
`ifdef SOBEL_BORDER_ZERO_EN
      FLUSH: begin
        if (w_slot_free) begin
          w_shift_col  = '0;
          w_emit       = 1'b1;
          w_clear      = 1'b1;
          w_line_end   = 1'b1;
          w_eol        = 1'b1;
          w_eof        = w_last_line;
          w_state_next = w_last_line ? WAIT_DONE : RUN;
        end
      end
`endif
      WAIT_DONE: begin
        if (w_slot_free) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  sobel_window_shift u_shift (
    .i_clk         (clk_i),
    .i_nreset      (nreset_i),
    .i_clear       (w_clear),
    .i_shift       (w_shift),
    .i_col         (w_shift_col),
    .o_win_shifted (w_win_shifted)
  );

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_width    <= '0;
      r_lines    <= '0;
      r_col_cnt  <= '0;
      r_line_cnt <= '0;
    end else if (w_start_ok) begin
      r_width    <= line_width_i;
      r_lines    <= num_lines_i;
      r_col_cnt  <= '0;
      r_line_cnt <= '0;
    end else if (w_line_end) begin
      r_col_cnt  <= '0;
      r_line_cnt <= r_line_cnt + CNT_W'(1);
    end else if (w_accept) begin
      r_col_cnt  <= r_col_cnt + CNT_W'(1);
    end
  end

  // Output slot: only loaded when free, so win/eol/eof hold while stalled.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_win_valid <= 1'b0;
      r_win       <= '0;
      r_eol       <= 1'b0;
      r_eof       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done;
      if (w_emit) begin
        r_win_valid <= 1'b1;
        r_win       <= w_win_shifted;
        r_eol       <= w_eol;
        r_eof       <= w_eof;
      end else if (win_ready_i) begin
        r_win_valid <= 1'b0;
        r_eol       <= 1'b0;
        r_eof       <= 1'b0;
      end
    end
  end

  assign win_valid_o = r_win_valid;
  assign win_o       = r_win;
  assign eol_o       = r_eol;
  assign eof_o       = r_eof;
  assign done_o      = r_done;
  assign busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb/tb_sobel_window_ctrl.sv - scoreboard bench for sobel_window_ctrl
// Expected windows are queued as columns are driven and popped at each window handshake.
module tb_sobel_window_ctrl;
  import sobel_window_ctrl_pkg::*;

  localparam int CNT_W = 10;
  localparam int PW    = PIXEL_WIDTH_IN;
`ifdef SOBEL_BORDER_ZERO_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  typedef logic [3*PW-1:0] col_t;
  typedef logic [127:0]    v_t;
  typedef struct packed {
    sobel_matrix win;
    logic        eol;
    logic        eof;
  } exp_t;

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  width = '0;
  logic [CNT_W-1:0]  lines = '0;
  logic              col_valid = 1'b0;
  logic              col_ready;
  col_t              col = '0;
  logic              win_valid;
  logic              win_ready = 1'b1;
  sobel_matrix       win;
  logic              eol, eof, busy, done;

  int   n_vec = 0, n_err = 0;
  int   cyc = 0, hs_cyc = -10, done_cnt = 0, n_win = 0;
  int   ready_mode = 0;
  bit   gap_mode = 1'b0;
  exp_t q[$];
  exp_t mon_e, held;
  logic prev_stall = 1'b0, prev_done = 1'b0;

  sobel_window_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .nreset_i     (nreset),
    .start_i      (start),
    .line_width_i (width),
    .num_lines_i  (lines),
    .col_valid_i  (col_valid),
    .col_ready_o  (col_ready),
    .col_i        (col),
    .win_valid_o  (win_valid),
    .win_ready_i  (win_ready),
    .win_o        (win),
    .eol_o        (eol),
    .eof_o        (eof),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input v_t obs, input v_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic sobel_matrix mk(input col_t a, input col_t b, input col_t c);
    sobel_matrix m;
    m.vector0.pix0 = a[0 +: PW];    m.vector0.pix1 = b[0 +: PW];    m.vector0.pix2 = c[0 +: PW];
    m.vector1.pix0 = a[PW +: PW];   m.vector1.pix1 = b[PW +: PW];   m.vector1.pix2 = c[PW +: PW];
    m.vector2.pix0 = a[2*PW +: PW]; m.vector2.pix1 = b[2*PW +: PW]; m.vector2.pix2 = c[2*PW +: PW];
    return m;
  endfunction

  task automatic push_win(input col_t a, input col_t b, input col_t c, input bit is_eol, input bit last_line);
    exp_t e;
    e.win = mk(a, b, c);
    e.eol = is_eol;
    e.eof = is_eol && last_line;
    q.push_back(e);
  endtask

  task automatic do_start(input int w, input int nl);
    width = CNT_W'(w);
    lines = CNT_W'(nl);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_col(input col_t c);
    int n = 0;
    if (gap_mode && $urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
    col_valid = 1'b1;
    col = c;
    @(negedge clk);
    while (!col_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("col_accepted", v_t'(col_ready), v_t'(1'b1));
    @(posedge clk); #1;
    col_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", v_t'(done_cnt - d0), v_t'(1));
    #1;
    chk("queue_drained", v_t'(q.size()), v_t'(0));
    chk("busy_after_done", v_t'(busy), v_t'(1'b0));
  endtask

  task automatic run_frame(input int w, input int nl, input int pat, input bit poke, input int abort_at);
    col_t ext[$];
    col_t c;
    int w0 = n_win;
    do_start(w, nl);
    for (int l = 0; l < nl; l++) begin
      ext = {};
      if (BORDER) ext.push_back('0);
      for (int i = 0; i < w; i++) begin
        if (abort_at >= 0 && i == abort_at) return;
        c = (pat == 0) ? col_t'({3{8'(10 * (i + 1))}}) : col_t'($urandom);
        ext.push_back(c);
        if (ext.size() >= 3)
          push_win(ext[$-2], ext[$-1], ext[$], !BORDER && (i == w - 1), l == nl - 1);
        send_col(c);
        if (poke && l == 0 && i == 1) begin
          do_start(5, 1);
          chk("start_ignored_busy", v_t'(busy), v_t'(1'b1));
        end
      end
      if (BORDER) begin
        ext.push_back('0);
        push_win(ext[$-2], ext[$-1], ext[$], 1'b1, l == nl - 1);
      end
    end
    wait_done(6000);
    chk("window_count", v_t'(n_win - w0), v_t'(nl * (BORDER ? w : w - 2)));
  endtask

  always @(negedge clk) begin
    if (!nreset) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", v_t'(win_valid), v_t'(1'b1));
        chk("hold_data", v_t'({win, eol, eof}), v_t'(held));
      end
      if (win_valid && win_ready) begin
        chk("window_expected", v_t'(q.size() != 0), v_t'(1'b1));
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          chk("win", v_t'(win), v_t'(mon_e.win));
          chk("eol", v_t'(eol), v_t'(mon_e.eol));
          chk("eof", v_t'(eof), v_t'(mon_e.eof));
        end
        hs_cyc = cyc;
        n_win++;
      end
      if (win_valid && !win_ready) chk("col_ready_stalled", v_t'(col_ready), v_t'(1'b0));
      if (done) begin
        done_cnt++;
        chk("done_latency", v_t'(cyc), v_t'(hs_cyc + 1));
      end
      if (prev_done) chk("done_pulse", v_t'(done), v_t'(1'b0));
      prev_stall = win_valid && !win_ready;
      held       = {win, eol, eof};
      prev_done  = done;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       win_ready = 1'b1;
        1:       win_ready = ~win_ready;
        default: win_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_win_valid", v_t'(win_valid), v_t'(1'b0));
    chk("rst_col_ready", v_t'(col_ready), v_t'(1'b0));
    chk("rst_busy", v_t'(busy), v_t'(1'b0));
    chk("rst_done", v_t'(done), v_t'(1'b0));
    chk("rst_eol_eof", v_t'({eol, eof}), v_t'(2'b00));
    chk("rst_win", v_t'(win), v_t'(0));
    @(posedge clk); #1;
    nreset = 1'b1;
    @(posedge clk); #1;

    do_start(2, 1);
    @(negedge clk);
    chk("bad_width_busy", v_t'(busy), v_t'(1'b0));
    chk("bad_width_col_ready", v_t'(col_ready), v_t'(1'b0));
    @(posedge clk); #1;
    do_start(5, 0);
    @(negedge clk);
    chk("bad_lines_busy", v_t'(busy), v_t'(1'b0));
    @(posedge clk); #1;

    ready_mode = 0;
    run_frame(4, 1, 0, 1'b0, -1);

    ready_mode = 1;
    run_frame(3, 3, 1, 1'b1, -1);

    ready_mode = 0;
    run_frame(8, 1, 1, 1'b0, 5);
    @(posedge clk); #1;
    d0 = done_cnt;
    nreset = 1'b0;
    @(negedge clk);
    chk("mid_rst_win_valid", v_t'(win_valid), v_t'(1'b0));
    chk("mid_rst_col_ready", v_t'(col_ready), v_t'(1'b0));
    chk("mid_rst_busy", v_t'(busy), v_t'(1'b0));
    chk("mid_rst_outs", v_t'({win, eol, eof, done}), v_t'(0));
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_done_after_reset", v_t'(done_cnt), v_t'(d0));
    chk("mid_rst_queue", v_t'(q.size()), v_t'(0));

    ready_mode = 2;
    gap_mode = 1'b1;
    run_frame(5, 2, 1, 1'b0, -1);
    run_frame(1023, 2, 1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
